control_unit: RTL and testbench

//  Hardwired Moore control FSM for the Mini-SRC datapath. Sits directly upstream of it.

---
 rtl/cu_pkg.sv | 57 +++++
 rtl/cu_if.sv | 19 +
 rtl/cu_op_class_decode.sv | 29 ++
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared types for the Mini-SRC control unit: opcodes, FSM states, instruction classes, strobe bundle.
// PAUSE exists only when SINGLE_STEP_EN is defined.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [4:0] {
    S_RESET, S_F0, S_F1, S_F1W, S_F2, S_T3,
    S_ALU_T4, S_CZ, S_ZWB, S_MD_T4, S_MD_T5, S_MD_T6,
    S_MA, S_LD_T6, S_LD_T6W, S_LD_T7, S_ST_T6, S_ST_T7,
    S_BR_T4, S_BR_T6, S_JAL_T4,
`ifdef SINGLE_STEP_EN
    S_PAUSE,
`endif
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU3, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } op_class_t;

  typedef struct packed {
    logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
    logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, CONin, JAL_flag;
  } ctl_t;

  function automatic logic is_run(state_t s);
    logic idle;
    idle = (s == S_RESET) || (s == S_HALT);
`ifdef SINGLE_STEP_EN
    idle = idle || (s == S_PAUSE);
`endif
    return !idle;
  endfunction

endpackage

// File: rtl/cu_if.sv
// Control unit <-> datapath bundle: IR/stop(/step) toward the FSM, run and strobes back.
// step is present only when SINGLE_STEP_EN is defined.
interface cu_if;
  logic [31:0]   IR;
  logic          stop;
`ifdef SINGLE_STEP_EN
  logic          step;
`endif
  logic          run;
  cu_pkg::ctl_t  ctl;

`ifdef SINGLE_STEP_EN
  modport master (input IR, stop, step, output run, ctl);
  modport slave  (output IR, stop, step, input run, ctl);
`else
  modport master (input IR, stop, output run, ctl);
  modport slave  (output IR, stop, input run, ctl);
`endif
endinterface

// File: rtl/cu_op_class_decode.sv
// Combinational opcode -> instruction-class decode; unused opcodes behave as nop.
module op_class_decode
  import cu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);
  always_comb begin
    op_class = C_NOP;
    case (opcode) inside
      OP_LD:            op_class = C_LD;
      OP_LDI:           op_class = C_LDI;
      OP_ST:            op_class = C_ST;
      [OP_ADD:OP_SHL]:  op_class = C_ALU3;
      [OP_ADDI:OP_ORI]: op_class = C_IMM;
      OP_MUL, OP_DIV:   op_class = C_MULDIV;
      OP_NEG, OP_NOT:   op_class = C_UNARY;
      OP_BR:            op_class = C_BR;
      OP_JR:            op_class = C_JR;
      OP_JAL:           op_class = C_JAL;
      OP_IN:            op_class = C_IN;
      OP_OUT:           op_class = C_OUT;
      OP_MFHI:          op_class = C_MFHI;
      OP_MFLO:          op_class = C_MFLO;
      OP_HALT:          op_class = C_HALT;
      default:          op_class = C_NOP;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// Hardwired control FSM for Mini-SRC: one state per cycle, memory reads stretched by MEM_WAIT.
// SINGLE_STEP_EN adds a PAUSE state at every instruction boundary, left by a step pulse.
module control_unit
  import cu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic clock,
  input  logic clear,
  cu_if.master bus
);
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

  state_t     state, state_nx, done_nx;
  op_class_t  op_class;
  logic [2:0] wait_cnt;
  logic       stop_q, stop_any;
  ctl_t       ctl;

  op_class_decode u_decode (.opcode(bus.IR[31:27]), .op_class(op_class));

  assign stop_any = bus.stop | stop_q;
`ifdef SINGLE_STEP_EN
  assign done_nx  = stop_any ? S_HALT : S_PAUSE;
`else
  assign done_nx  = stop_any ? S_HALT : S_F0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_RESET;
      wait_cnt <= 3'd0;
      stop_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_F0 || state == S_MA)
        wait_cnt <= WAIT_INIT;
      else if (wait_cnt != 3'd0 && (state == S_F1 || state == S_F1W ||
                                    state == S_LD_T6 || state == S_LD_T6W))
        wait_cnt <= wait_cnt - 3'd1;
      // stop is remembered until the boundary that consumes it
      if (state_nx == S_F0 || !is_run(state_nx))
        stop_q <= 1'b0;
      else if (bus.stop)
        stop_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:            state_nx = S_F0;
      S_F0:               state_nx = S_F1;
      S_F1, S_F1W:        state_nx = (wait_cnt == 3'd0) ? S_F2 : S_F1W;
      S_F2:               state_nx = S_T3;
      S_T3: begin
        case (op_class)
          C_ALU3:                      state_nx = S_ALU_T4;
          C_IMM, C_LD, C_LDI, C_ST:    state_nx = S_CZ;
          C_UNARY:                     state_nx = S_ZWB;
          C_MULDIV:                    state_nx = S_MD_T4;
          C_BR:                        state_nx = S_BR_T4;
          C_JAL:                       state_nx = S_JAL_T4;
          C_HALT:                      state_nx = S_HALT;
          default:                     state_nx = done_nx;
        endcase
      end
      S_ALU_T4:           state_nx = S_ZWB;
      S_CZ: begin
        case (op_class)
          C_LD, C_ST:     state_nx = S_MA;
          C_BR:           state_nx = S_BR_T6;
          default:        state_nx = S_ZWB;
        endcase
      end
      S_MD_T4:            state_nx = S_MD_T5;
      S_MD_T5:            state_nx = S_MD_T6;
      S_MA:               state_nx = (op_class == C_ST) ? S_ST_T6 : S_LD_T6;
      S_LD_T6, S_LD_T6W:  state_nx = (wait_cnt == 3'd0) ? S_LD_T7 : S_LD_T6W;
      S_ST_T6:            state_nx = S_ST_T7;
      S_BR_T4:            state_nx = S_CZ;
      S_ZWB, S_MD_T6, S_LD_T7, S_ST_T7, S_BR_T6, S_JAL_T4:
                          state_nx = done_nx;
`ifdef SINGLE_STEP_EN
      S_PAUSE:            state_nx = bus.stop ? S_HALT : (bus.step ? S_F0 : S_PAUSE);
`endif
      S_HALT:             state_nx = S_HALT;
      default:            state_nx = S_RESET;
    endcase
  end

  // T3 is the single dispatch step, so its strobes also look at the (now stable) class
  always_comb begin
    ctl = '0;
    case (state)
      S_F0:      begin ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.Zlowin = 1'b1; end
      S_F1:      begin ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; ctl.Read = 1'b1; ctl.MDRin = 1'b1; end
      S_F1W, S_LD_T6, S_LD_T6W:
                 begin ctl.Read = 1'b1; ctl.MDRin = 1'b1; end
      S_F2:      begin ctl.MDRout = 1'b1; ctl.IRin = 1'b1; end
      S_T3: begin
        case (op_class)
          C_ALU3, C_IMM:      begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
          C_UNARY:            begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zlowin = 1'b1; end
          C_MULDIV:           begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
          C_LD, C_LDI, C_ST:  begin ctl.Grb = 1'b1; ctl.BAout = 1'b1; ctl.Rout = 1'b1; ctl.Yin = 1'b1; end
          C_BR:               begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.CONin = 1'b1; end
          C_JR:               begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
          C_JAL:              begin ctl.PCout = 1'b1; ctl.JAL_flag = 1'b1; end
          C_IN:               begin ctl.InPortout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
          C_OUT:              begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.OutPortin = 1'b1; end
          C_MFHI:             begin ctl.HIout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
          C_MFLO:             begin ctl.LOout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
          default:            ctl = '0;
        endcase
      end
      S_ALU_T4:  begin ctl.Grc = 1'b1; ctl.Rout = 1'b1; ctl.Zlowin = 1'b1; end
      S_CZ:      begin ctl.Cout = 1'b1; ctl.Zlowin = 1'b1; end
      S_ZWB:     begin ctl.Zlowout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
      S_MD_T4:   begin ctl.Grb = 1'b1; ctl.Rout = 1'b1; ctl.Zlowin = 1'b1; ctl.Zhighin = 1'b1; end
      S_MD_T5:   begin ctl.Zlowout = 1'b1; ctl.LOin = 1'b1; end
      S_MD_T6:   begin ctl.Zhighout = 1'b1; ctl.HIin = 1'b1; end
      S_MA:      begin ctl.Zlowout = 1'b1; ctl.MARin = 1'b1; end
      S_LD_T7:   begin ctl.MDRout = 1'b1; ctl.Gra = 1'b1; ctl.Rin = 1'b1; end
      S_ST_T6:   begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.MDRin = 1'b1; end
      S_ST_T7:   ctl.Write = 1'b1;
      S_BR_T4:   begin ctl.PCout = 1'b1; ctl.Yin = 1'b1; end
      S_BR_T6:   begin ctl.Zlowout = 1'b1; ctl.PCin = 1'b1; end
      S_JAL_T4:  begin ctl.Gra = 1'b1; ctl.Rout = 1'b1; ctl.PCin = 1'b1; end
      default:   ctl = '0;
    endcase
  end

  assign bus.ctl = ctl;
  assign bus.run = is_run(state);

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (MEM_WAIT=1 and 3) checked cycle by cycle against a strobe-list model.
// Table vectors, clear/stop corner sequences, then random instructions with random stop pulses.
module tb_control_unit;
  import cu_pkg::*;

  logic clock = 1'b0;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  cu_if bus1 ();
  cu_if bus3 ();

  control_unit #(.MEM_WAIT(1)) dut1 (.clock(clock), .clear(clear), .bus(bus1.master));
  control_unit #(.MEM_WAIT(3)) dut3 (.clock(clock), .clear(clear), .bus(bus3.master));

  string names [29] = '{
    "PCout", "Zhighout", "Zlowout", "HIout", "LOout", "MDRout", "InPortout", "Cout", "BAout",
    "MARin", "PCin", "MDRin", "IRin", "Yin", "HIin", "LOin", "Zhighin", "Zlowin", "OutPortin",
    "IncPC", "Read", "Write", "Gra", "Grb", "Grc", "Rin", "Rout", "CONin", "JAL_flag"};

  string tr[$];

  typedef struct {
    logic [31:0] ir;
    int          d;
    int          stop_t;
    int          rd;
    int          wr;
    int          halt;
  } vec_t;

  vec_t vt [14];

  function automatic ctl_t mk(input string s);
    ctl_t  c;
    string tok;
    c   = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.substr(i, i) == ",") begin
        for (int j = 0; j < $bits(ctl_t); j++)
          if (names[j] == tok) c[$bits(ctl_t)-1-j] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return c;
  endfunction

  // Expected per-cycle strobe lists, written straight from the instruction table.
  task automatic build(input logic [4:0] op, input int w, output bit self_halt);
    int o;
    o = int'(op);
    self_halt = 1'b0;
    tr.delete();
    tr.push_back("PCout,MARin,IncPC,Zlowin");
    tr.push_back("Zlowout,PCin,Read,MDRin");
    repeat (w) tr.push_back("Read,MDRin");
    tr.push_back("MDRout,IRin");
    if (o >= 3 && o <= 11) begin
      tr.push_back("Grb,Rout,Yin"); tr.push_back("Grc,Rout,Zlowin"); tr.push_back("Zlowout,Gra,Rin");
    end else if (o >= 12 && o <= 14) begin
      tr.push_back("Grb,Rout,Yin"); tr.push_back("Cout,Zlowin"); tr.push_back("Zlowout,Gra,Rin");
    end else if (o == 15 || o == 16) begin
      tr.push_back("Gra,Rout,Yin"); tr.push_back("Grb,Rout,Zlowin,Zhighin");
      tr.push_back("Zlowout,LOin"); tr.push_back("Zhighout,HIin");
    end else if (o == 17 || o == 18) begin
      tr.push_back("Grb,Rout,Zlowin"); tr.push_back("Zlowout,Gra,Rin");
    end else if (o <= 2) begin
      tr.push_back("Grb,BAout,Rout,Yin"); tr.push_back("Cout,Zlowin");
      if (o == 1) tr.push_back("Zlowout,Gra,Rin");
      else tr.push_back("Zlowout,MARin");
      if (o == 0) begin
        repeat (w + 1) tr.push_back("Read,MDRin");
        tr.push_back("MDRout,Gra,Rin");
      end else if (o == 2) begin
        tr.push_back("Gra,Rout,MDRin"); tr.push_back("Write");
      end
    end else if (o == 19) begin
      tr.push_back("Gra,Rout,CONin"); tr.push_back("PCout,Yin");
      tr.push_back("Cout,Zlowin"); tr.push_back("Zlowout,PCin");
    end else if (o == 20) tr.push_back("Gra,Rout,PCin");
    else if (o == 21) begin
      tr.push_back("PCout,JAL_flag"); tr.push_back("Gra,Rout,PCin");
    end
    else if (o == 22) tr.push_back("InPortout,Gra,Rin");
    else if (o == 23) tr.push_back("Gra,Rout,OutPortin");
    else if (o == 24) tr.push_back("HIout,Gra,Rin");
    else if (o == 25) tr.push_back("LOout,Gra,Rin");
    else begin
      tr.push_back("");
      self_halt = (o == 27);
    end
  endtask

  function automatic ctl_t get_ctl(input int d);
    return (d != 0) ? bus3.ctl : bus1.ctl;
  endfunction

  function automatic int get_run(input int d);
    return (d != 0) ? int'(bus3.run) : int'(bus1.run);
  endfunction

  task automatic set_stop(input int d, input logic v);
    if (d != 0) bus3.stop = v; else bus1.stop = v;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic set_step(input int d, input logic v);
    if (d != 0) bus3.step = v; else bus1.step = v;
  endtask
`endif

  task automatic chk_ctl(input string nm, input int d, input int k, input ctl_t got, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d got=%h want=%h", nm, d, k, got, exp);
    end
  endtask

  task automatic chk_val(input string nm, input int d, input int k, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s dut%0d cycle=%0d got=%0d want=%0d", nm, d, k, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first F0 cycle after release.
  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk_ctl("clear_async_ctl", 0, -1, bus1.ctl, '0);
    chk_val("clear_async_run", 0, -1, int'(bus1.run), 0);
    chk_ctl("clear_async_ctl", 1, -1, bus3.ctl, '0);
    @(posedge clock);
    @(negedge clock);
    bus1.stop = 1'b0;
    bus3.stop = 1'b0;
    clear     = 1'b0;
    chk_ctl("reset_ctl", 0, -1, bus1.ctl, '0);
    chk_val("reset_run", 1, -1, int'(bus3.run), 0);
    @(negedge clock);
  endtask

  // Called at the negedge of an F0 cycle.
  task automatic run_instr(input int d, input logic [31:0] ir, input int stop_k, input int clear_k,
                           output int rd_n, output int wr_n, output bit halted);
    bit   self_halt;
    ctl_t got;
    int   exp_halt;
    build(ir[31:27], (d != 0) ? 3 : 1, self_halt);
    rd_n = 0; wr_n = 0; halted = 1'b0;
    if (d != 0) bus3.IR = ir; else bus1.IR = ir;
    for (int k = 0; k < tr.size(); k++) begin
      if (k > 0) @(negedge clock);
`ifdef SINGLE_STEP_EN
      set_step(d, 1'b0);
`endif
      set_stop(d, k == stop_k);
      got = get_ctl(d);
      rd_n += int'(got.Read);
      wr_n += int'(got.Write);
      chk_ctl("strobes", d, k, got, mk(tr[k]));
      chk_val("run", d, k, get_run(d), 1);
      if (k == clear_k) begin
        do_clear();
        return;
      end
    end
    exp_halt = (self_halt || stop_k >= 0) ? 1 : 0;
    @(negedge clock);
    set_stop(d, 1'b0);
`ifdef SINGLE_STEP_EN
    chk_ctl("pause_ctl", d, -1, get_ctl(d), '0);
    chk_val("pause_run", d, -1, get_run(d), 0);
    @(negedge clock);
    chk_val("pause_hold_run", d, -1, get_run(d), 0);
    set_step(d, 1'b1);
    @(negedge clock);
    set_step(d, 1'b0);
`endif
    halted = (get_run(d) == 0);
    chk_val("halted", d, -1, int'(halted), exp_halt);
    if (halted) begin
      repeat (2) begin
        @(negedge clock);
        chk_ctl("halt_ctl", d, -1, get_ctl(d), '0);
        chk_val("halt_run", d, -1, get_run(d), 0);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cur_d, sk, rd, wr, d, w;
    bit          h, need_clr;
    logic [31:0] ir;

    clear = 1'b0;
    bus1.IR = 32'hD000_0000; bus3.IR = 32'hD000_0000;
    bus1.stop = 1'b0; bus3.stop = 1'b0;
`ifdef SINGLE_STEP_EN
    bus1.step = 1'b0; bus3.step = 1'b0;
`endif

    //          ir            dut stop_t reads writes halt
    vt[0]  = '{32'h18A0_0000, 0, -1, 2, 0, 0};  // add R1,R2,R3
    vt[1]  = '{32'h0088_0004, 1, -1, 8, 0, 0};  // ld, 3 wait cycles
    vt[2]  = '{32'h1088_0004, 0, -1, 2, 1, 0};  // st
    vt[3]  = '{32'h1088_0004, 1, -1, 4, 1, 0};  // st, 3 wait cycles
    vt[4]  = '{32'h0088_0004, 0, -1, 4, 0, 0};  // ld
    vt[5]  = '{32'h0888_0004, 0, -1, 2, 0, 0};  // ldi
    vt[6]  = '{32'hA880_0000, 0, -1, 2, 0, 0};  // jal
    vt[7]  = '{32'hD000_0000, 0, -1, 2, 0, 0};  // nop
    vt[8]  = '{32'h9880_0000, 0, -1, 2, 0, 0};  // br
    vt[9]  = '{32'hF800_0000, 0, -1, 2, 0, 0};  // unused opcode
    vt[10] = '{32'h8000_0000, 1, -1, 4, 0, 0};  // div
    vt[11] = '{32'h7888_0000, 0,  3, 2, 0, 1};  // mul, stop pulsed in T3
    vt[12] = '{32'h18A0_0000, 0,  5, 2, 0, 1};  // add, stop in last step
    vt[13] = '{32'hD800_0000, 1, -1, 4, 0, 1};  // halt

    @(negedge clock);
    need_clr = 1'b1;
    cur_d    = -1;
    for (int i = 0; i < 14; i++) begin
      if (need_clr || vt[i].d != cur_d) begin
        do_clear();
        cur_d = vt[i].d;
      end
      sk = (vt[i].stop_t < 0) ? -1 : vt[i].stop_t + ((vt[i].d != 0) ? 3 : 1);
      run_instr(vt[i].d, vt[i].ir, sk, -1, rd, wr, h);
      chk_val("vec_reads", vt[i].d, i, rd, vt[i].rd);
      chk_val("vec_writes", vt[i].d, i, wr, vt[i].wr);
      chk_val("vec_halt", vt[i].d, i, int'(h), vt[i].halt);
      need_clr = h;
    end

    // stop latched in T3, clear in T4: the latched stop must not survive the clear
    do_clear();
    run_instr(0, 32'h18A0_0000, 4, 5, rd, wr, h);
    run_instr(0, 32'h18A0_0000, -1, -1, rd, wr, h);
    // stop and clear together in T4
    run_instr(0, 32'h18A0_0000, 5, 5, rd, wr, h);
    run_instr(0, 32'h18A0_0000, -1, -1, rd, wr, h);
    cur_d    = 0;
    need_clr = h;

    for (int n = 0; n < 40; n++) begin
      d  = int'($urandom_range(1, 0));
      w  = (d != 0) ? 3 : 1;
      ir = $urandom;
      sk = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3 + w, 0)) : -1;
      if (need_clr || d != cur_d) begin
        do_clear();
        cur_d = d;
      end
      run_instr(d, ir, sk, -1, rd, wr, h);
      need_clr = h;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
